// File: rtl/bram_line_adapter.sv
// Line-to-beat adapter: splits 256-bit line reads/writes into BRAM beats on a native port.
// Optional macro LINE_ADAPTER_ALIGN_CHECK_EN rejects requests not aligned to a line.
module bram_line_adapter #(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned BEATS         = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   req_addr_i,
   input  logic                          req_read_i,
   input  logic                          req_write_i,
   input  logic [BEATS*DATA_WIDTH-1:0]   req_wdata_i,
   output logic [BEATS*DATA_WIDTH-1:0]   resp_rdata_o,
   output logic                          resp_o,
   output logic                          busy_o,
   output logic                          err_o,
   output logic                          ena_o,
   output logic                          wea_o,
   output logic [ADDRESS_WIDTH-1:0]      addra_o,
   output logic [DATA_WIDTH-1:0]         dina_o,
   input  logic [DATA_WIDTH-1:0]         douta_i
);

   localparam int unsigned LineOffW = $clog2(BEATS * DATA_WIDTH / 8);
   localparam int unsigned BeatW    = $clog2(BEATS);
   localparam int unsigned LineW    = 32 - LineOffW;
   localparam int unsigned WordW    = LineW + BeatW;

   typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StResp} state_e;

   state_e                             r_state;
   state_e                             w_state_next;
   logic [LineW-1:0]                   r_line;
   logic [BEATS-1:0][DATA_WIDTH-1:0]   r_wdata;
   logic [BEATS-1:0][DATA_WIDTH-1:0]   r_rdata;
   logic [BeatW-1:0]                   r_beat;
   logic [BeatW-1:0]                   r_cap_beat;
   logic                               r_cap_pend;
   logic                               w_req;
   logic                               w_accept;
   logic                               w_last_beat;
   logic                               w_misalign;
   logic                               w_err;
   logic [WordW-1:0]                   w_word;

   assign w_req       = req_read_i || req_write_i;
   assign w_accept    = (r_state == StIdle) && w_req;
   assign w_last_beat = (r_beat == BeatW'(BEATS - 1));
   assign w_word      = {r_line, r_beat};

`ifdef LINE_ADAPTER_ALIGN_CHECK_EN
   logic r_err;

   assign w_misalign = |req_addr_i[LineOffW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= w_misalign;
      end
   end

   assign w_err = r_err;
`else
   logic w_unused_addr;

   assign w_unused_addr = ^req_addr_i[LineOffW-1:0];
   assign w_misalign    = 1'b0;
   assign w_err         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (w_req) begin
               if (w_misalign)       w_state_next = StResp;
               else if (req_read_i)  w_state_next = StRead;
               else                  w_state_next = StWrite;
            end
         end
         StRead:  if (w_last_beat) w_state_next = StDrain;
         StWrite: if (w_last_beat) w_state_next = StResp;
         StDrain: w_state_next = StResp;
         StResp:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      ena_o   = (r_state == StRead) || (r_state == StWrite);
      wea_o   = (r_state == StWrite);
      addra_o = '0;
      dina_o  = '0;
      if ((r_state == StRead) || (r_state == StWrite)) begin
         addra_o = ADDRESS_WIDTH'(w_word);
      end
      if (r_state == StWrite) begin
         dina_o = r_wdata[r_beat];
      end
      resp_o = (r_state == StResp);
      busy_o = (r_state != StIdle);
      err_o  = (r_state == StResp) && w_err;
   end

   // Read data arrives one cycle after issue, so capture lags the beat counter by one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_line     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_beat     <= '0;
         r_cap_beat <= '0;
         r_cap_pend <= 1'b0;
      end else begin
         if (w_accept) begin
            r_line  <= req_addr_i[31:LineOffW];
            r_wdata <= req_wdata_i;
         end
         if ((r_state == StRead) || (r_state == StWrite)) begin
            r_beat <= r_beat + 1'b1;
         end else begin
            r_beat <= '0;
         end
         r_cap_pend <= (r_state == StRead);
         r_cap_beat <= r_beat;
         if (r_cap_pend) begin
            r_rdata[r_cap_beat] <= douta_i;
         end
      end
   end

   assign resp_rdata_o = r_rdata;

endmodule

// File: tb/tb_bram_line_adapter.sv
// Directed bench for bram_line_adapter with a 1-cycle-latency BRAM model.
// Build with LINE_ADAPTER_ALIGN_CHECK_EN defined to exercise the alignment-error path.
module tb_bram_line_adapter;

   logic          clk;
   logic          rst;
   logic [31:0]   req_addr_i;
   logic          req_read_i;
   logic          req_write_i;
   logic [255:0]  req_wdata_i;
   logic [255:0]  resp_rdata_o;
   logic          resp_o;
   logic          busy_o;
   logic          err_o;
   logic          ena_o;
   logic          wea_o;
   logic [31:0]   addra_o;
   logic [63:0]   dina_o;
   logic [63:0]   douta_i;

   int n_checks = 0;
   int n_fails  = 0;

   bram_line_adapter #(
      .DATA_WIDTH    (64),
      .ADDRESS_WIDTH (32),
      .BEATS         (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_addr_i   (req_addr_i),
      .req_read_i   (req_read_i),
      .req_write_i  (req_write_i),
      .req_wdata_i  (req_wdata_i),
      .resp_rdata_o (resp_rdata_o),
      .resp_o       (resp_o),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .ena_o        (ena_o),
      .wea_o        (wea_o),
      .addra_o      (addra_o),
      .dina_o       (dina_o),
      .douta_i      (douta_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] a_val(int k);
      return 64'hA5A5_0000_1111_0000 + 64'(k);
   endfunction

   function automatic logic [63:0] b_val(int k);
      return 64'hB00B_2222_0000_0000 + 64'(k);
   endfunction

   // Contents of any BRAM word not written since reset.
   function automatic logic [63:0] c_val(int idx);
      return 64'hC0DE_0000_0000_0000 + 64'(idx);
   endfunction

   // BRAM model: 256 words, registered read output.
   logic [63:0]  mem [0:255];
   logic [255:0] written;

   always @(posedge clk) begin
      if (rst) begin
         written <= '0;
         douta_i <= '0;
      end else if (ena_o) begin
         if (wea_o) begin
            mem[addra_o[7:0]]     <= dina_o;
            written[addra_o[7:0]] <= 1'b1;
         end else begin
            douta_i <= written[addra_o[7:0]] ? mem[addra_o[7:0]] : c_val(int'(addra_o[7:0]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      req_read_i  = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 32'h100;
      req_wdata_i = '0;
      step();
      step();
      rst        = 1'b0;
      req_read_i = 1'b0;
      n_checks++;
      if ({resp_o, busy_o, err_o, ena_o, wea_o} !== 5'b0) begin
         n_fails++;
         $display("FAIL reset_ctrl: got %b want 00000", {resp_o, busy_o, err_o, ena_o, wea_o});
      end
      n_checks++;
      if ({addra_o, dina_o} !== 96'h0) begin
         n_fails++;
         $display("FAIL reset_bus: got addra %h dina %h want 0", addra_o, dina_o);
      end
      n_checks++;
      if (resp_rdata_o !== 256'h0) begin
         n_fails++;
         $display("FAIL reset_rdata: got %h want 0", resp_rdata_o);
      end
      step();
      n_checks++;
      if ({busy_o, ena_o} !== 2'b00) begin
         n_fails++;
         $display("FAIL reset_req_ignored: got busy/ena %b want 00", {busy_o, ena_o});
      end
   endtask

   task automatic test_write();
      logic [99:0] got, exp;
      req_addr_i  = 32'h100;
      req_wdata_i = {a_val(3), a_val(2), a_val(1), a_val(0)};
      req_write_i = 1'b1;
      step();
      req_write_i = 1'b0;
      req_addr_i  = 32'hFFFF_FFE0;
      req_wdata_i = '1;
      for (int k = 0; k < 4; k++) begin
         got = {ena_o, wea_o, addra_o, dina_o, resp_o, busy_o};
         exp = {1'b1, 1'b1, 32'h20 + 32'(k), a_val(k), 1'b0, 1'b1};
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL write_beat%0d: got %h want %h", k, got, exp);
         end
         step();
      end
      got = {ena_o, wea_o, addra_o, dina_o, resp_o, busy_o};
      exp = {2'b00, 32'h0, 64'h0, 1'b1, 1'b1};
      n_checks++;
      if (got !== exp || err_o !== 1'b0) begin
         n_fails++;
         $display("FAIL write_resp: got %h err %b want %h err 0", got, err_o, exp);
      end
      step();
      n_checks++;
      if ({resp_o, busy_o} !== 2'b00) begin
         n_fails++;
         $display("FAIL write_done: got resp/busy %b want 00", {resp_o, busy_o});
      end
   endtask

   task automatic test_read();
      logic [99:0] got, exp;
      req_addr_i = 32'h100;
      req_read_i = 1'b1;
      step();
      req_read_i = 1'b0;
      req_addr_i = 32'hFFFF_FFE0;
      for (int k = 0; k < 4; k++) begin
         got = {ena_o, wea_o, addra_o, dina_o, resp_o, busy_o};
         exp = {1'b1, 1'b0, 32'h20 + 32'(k), 64'h0, 1'b0, 1'b1};
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL read_beat%0d: got %h want %h", k, got, exp);
         end
         step();
      end
      n_checks++;
      if ({ena_o, resp_o, busy_o} !== 3'b001) begin
         n_fails++;
         $display("FAIL read_drain: got ena/resp/busy %b want 001", {ena_o, resp_o, busy_o});
      end
      step();
      n_checks++;
      if ({resp_o, err_o} !== 2'b10
          || resp_rdata_o !== {a_val(3), a_val(2), a_val(1), a_val(0)}) begin
         n_fails++;
         $display("FAIL read_resp: got resp/err %b data %h want 10 data %h", {resp_o, err_o},
                  resp_rdata_o, {a_val(3), a_val(2), a_val(1), a_val(0)});
      end
      step();
      n_checks++;
      if ({resp_o, busy_o} !== 2'b00
          || resp_rdata_o !== {a_val(3), a_val(2), a_val(1), a_val(0)}) begin
         n_fails++;
         $display("FAIL read_hold: got resp/busy %b data %h", {resp_o, busy_o}, resp_rdata_o);
      end
   endtask

   task automatic test_priority();
      logic [35:0] got, exp;
      req_addr_i  = 32'h40;
      req_wdata_i = {b_val(7), b_val(6), b_val(5), b_val(4)};
      req_read_i  = 1'b1;
      req_write_i = 1'b1;
      step();
      req_read_i  = 1'b0;
      req_write_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         got = {ena_o, wea_o, addra_o, resp_o, busy_o};
         exp = {1'b1, 1'b0, 32'h8 + 32'(k), 1'b0, 1'b1};
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL prio_beat%0d: got %h want %h", k, got, exp);
         end
         req_write_i = (k == 1);
         step();
      end
      n_checks++;
      if ({ena_o, resp_o, busy_o} !== 3'b001) begin
         n_fails++;
         $display("FAIL prio_drain: got ena/resp/busy %b want 001", {ena_o, resp_o, busy_o});
      end
      step();
      n_checks++;
      if (resp_o !== 1'b1 || resp_rdata_o !== {c_val(11), c_val(10), c_val(9), c_val(8)}) begin
         n_fails++;
         $display("FAIL prio_resp: got resp %b data %h want 1 data %h", resp_o, resp_rdata_o,
                  {c_val(11), c_val(10), c_val(9), c_val(8)});
      end
      for (int k = 0; k < 2; k++) begin
         step();
         n_checks++;
         if ({ena_o, busy_o, resp_o} !== 3'b000) begin
            n_fails++;
            $display("FAIL prio_no_extra%0d: got ena/busy/resp %b want 000", k,
                     {ena_o, busy_o, resp_o});
         end
      end
   endtask

   task automatic test_align();
      req_addr_i = 32'h104;
      req_read_i = 1'b1;
      step();
      req_read_i = 1'b0;
`ifdef LINE_ADAPTER_ALIGN_CHECK_EN
      n_checks++;
      if ({resp_o, err_o, ena_o, busy_o} !== 4'b1101
          || resp_rdata_o !== {c_val(11), c_val(10), c_val(9), c_val(8)}) begin
         n_fails++;
         $display("FAIL align_err: got resp/err/ena/busy %b data %h want 1101 data unchanged",
                  {resp_o, err_o, ena_o, busy_o}, resp_rdata_o);
      end
      step();
      n_checks++;
      if ({resp_o, err_o, ena_o, busy_o} !== 4'b0000) begin
         n_fails++;
         $display("FAIL align_done: got resp/err/ena/busy %b want 0000",
                  {resp_o, err_o, ena_o, busy_o});
      end
`else
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if ({ena_o, wea_o, addra_o} !== {2'b10, 32'h20 + 32'(k)}) begin
            n_fails++;
            $display("FAIL align_beat%0d: got ena/wea %b addra %h want 10 %h", k,
                     {ena_o, wea_o}, addra_o, 32'h20 + 32'(k));
         end
         step();
      end
      step();
      n_checks++;
      if ({resp_o, err_o} !== 2'b10
          || resp_rdata_o !== {a_val(3), a_val(2), a_val(1), a_val(0)}) begin
         n_fails++;
         $display("FAIL align_resp: got resp/err %b data %h want 10", {resp_o, err_o},
                  resp_rdata_o);
      end
      step();
`endif
   endtask

   task automatic test_back_to_back();
      logic [97:0] got, exp;
      req_addr_i = 32'h100;
      req_read_i = 1'b1;
      step();
      req_read_i = 1'b0;
      for (int k = 0; k < 5; k++) step();
      n_checks++;
      if (resp_o !== 1'b1 || resp_rdata_o !== {a_val(3), a_val(2), a_val(1), a_val(0)}) begin
         n_fails++;
         $display("FAIL b2b_read_resp: got resp %b data %h", resp_o, resp_rdata_o);
      end
      // Held through RESP (must be ignored there) and the following IDLE cycle.
      req_addr_i  = 32'h40;
      req_wdata_i = {b_val(3), b_val(2), b_val(1), b_val(0)};
      req_write_i = 1'b1;
      step();
      n_checks++;
      if ({busy_o, resp_o, ena_o} !== 3'b000) begin
         n_fails++;
         $display("FAIL b2b_gap: got busy/resp/ena %b want 000", {busy_o, resp_o, ena_o});
      end
      step();
      req_write_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         got = {ena_o, wea_o, addra_o, dina_o};
         exp = {2'b11, 32'h8 + 32'(k), b_val(k)};
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL b2b_write_beat%0d: got %h want %h", k, got, exp);
         end
         step();
      end
      n_checks++;
      if (resp_o !== 1'b1) begin
         n_fails++;
         $display("FAIL b2b_write_resp: got resp %b want 1", resp_o);
      end
      step();
      req_addr_i = 32'h40;
      req_read_i = 1'b1;
      step();
      req_read_i = 1'b0;
      for (int k = 0; k < 5; k++) step();
      n_checks++;
      if (resp_o !== 1'b1 || resp_rdata_o !== {b_val(3), b_val(2), b_val(1), b_val(0)}) begin
         n_fails++;
         $display("FAIL b2b_readback: got resp %b data %h want 1 data %h", resp_o, resp_rdata_o,
                  {b_val(3), b_val(2), b_val(1), b_val(0)});
      end
      step();
   endtask

   task automatic test_reset_mid();
      req_addr_i = 32'h100;
      req_read_i = 1'b1;
      step();
      req_read_i = 1'b0;
      step();
      n_checks++;
      if ({ena_o, addra_o} !== {1'b1, 32'h21}) begin
         n_fails++;
         $display("FAIL rstmid_pre: got ena %b addra %h want 1 21", ena_o, addra_o);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         n_checks++;
         if ({ena_o, busy_o, resp_o} !== 3'b000 || resp_rdata_o !== 256'h0) begin
            n_fails++;
            $display("FAIL rstmid_cyc%0d: got ena/busy/resp %b data %h want 000 data 0", k,
                     {ena_o, busy_o, resp_o}, resp_rdata_o);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_priority();
      test_align();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
